// File: rtl/pixel_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers hold the previous rows; a register window shifts one column per accepted pixel.
module pixel_window_gen #(
    parameter int PIX_WIDTH  = 24,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIX_WIDTH-1:0]   idat,
    input  logic                   ival,
    output logic [9*PIX_WIDTH-1:0] odat,
    output logic                   oval,
    output logic [CNT_WIDTH-1:0]   orow,
    output logic [CNT_WIDTH-1:0]   ocol,
    output logic                   oeof
);

    localparam int ADDR_W = $clog2(IMG_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_COL = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] FIRST_OK = CNT_WIDTH'(2);

    logic [CNT_WIDTH-1:0] r_col_cnt;
    logic [CNT_WIDTH-1:0] r_row_cnt;
    logic [CNT_WIDTH-1:0] w_col_next;
    logic [CNT_WIDTH-1:0] w_row_next;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_win_ok;
    logic [ADDR_W-1:0]    w_addr;

    // line1 holds row-1, line0 holds row-2; no reset, contents are rewritten before use.
    logic [PIX_WIDTH-1:0] r_line0 [IMG_WIDTH];
    logic [PIX_WIDTH-1:0] r_line1 [IMG_WIDTH];
    logic [PIX_WIDTH-1:0] w_line0_rd;
    logic [PIX_WIDTH-1:0] w_line1_rd;

    logic [PIX_WIDTH-1:0] r_win [3][3];
    logic [PIX_WIDTH-1:0] w_new_col [3];

    logic                 r_oval;
    logic                 r_oeof;
    logic [CNT_WIDTH-1:0] r_orow;
    logic [CNT_WIDTH-1:0] r_ocol;

    assign w_addr     = r_col_cnt[ADDR_W-1:0];
    assign w_line0_rd = r_line0[w_addr];
    assign w_line1_rd = r_line1[w_addr];

    assign w_new_col[0] = w_line0_rd;
    assign w_new_col[1] = w_line1_rd;
    assign w_new_col[2] = idat;

    always_comb begin
        w_col_last = (r_col_cnt == LAST_COL);
        w_row_last = (r_row_cnt == LAST_ROW);
        w_win_ok   = (r_row_cnt >= FIRST_OK) && (r_col_cnt >= FIRST_OK);
        w_col_next = r_col_cnt + CNT_WIDTH'(1);
        w_row_next = r_row_cnt;
        if (w_col_last) begin
            w_col_next = '0;
            w_row_next = w_row_last ? '0 : r_row_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (ival) begin
            r_col_cnt <= w_col_next;
            r_row_cnt <= w_row_next;
        end
    end

    // Read-before-write: the same address is read combinationally above in this cycle.
    always_ff @(posedge clk) begin
        if (ival) begin
            r_line0[w_addr] <= w_line1_rd;
            r_line1[w_addr] <= idat;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            for (gj = 0; gj < 3; gj++) begin : g_col
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_win[gi][gj] <= '0;
                    end else if (ival) begin
                        if (gj == 2) r_win[gi][gj] <= w_new_col[gi];
                        else         r_win[gi][gj] <= r_win[gi][(gj == 2) ? 2 : gj + 1];
                    end
                end
                assign odat[PIX_WIDTH*(3*gi+gj) +: PIX_WIDTH] = r_win[gi][gj];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oval <= 1'b0;
            r_oeof <= 1'b0;
            r_orow <= '0;
            r_ocol <= '0;
        end else begin
            r_oval <= ival && w_win_ok;
            r_oeof <= ival && w_row_last && w_col_last;
            if (ival) begin
                r_orow <= r_row_cnt;
                r_ocol <= r_col_cnt;
            end
        end
    end

    assign oval = r_oval;
    assign oeof = r_oeof;
    assign orow = r_orow;
    assign ocol = r_ocol;

endmodule

// File: tb/tb_pixel_window_gen.sv
// Scoreboard bench for pixel_window_gen on a 4x4 image with pixel value = base + raster index.
module tb_pixel_window_gen;

    localparam int PW = 24;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [PW-1:0]   idat = '0;
    logic            ival = 1'b0;
    logic [9*PW-1:0] odat;
    logic            oval;
    logic [CW-1:0]   orow;
    logic [CW-1:0]   ocol;
    logic            oeof;

    pixel_window_gen #(.PIX_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .idat(idat), .ival(ival),
        .odat(odat), .oval(oval), .orow(orow), .ocol(ocol), .oeof(oeof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9*PW-1:0] dat;
        logic [CW-1:0]   row;
        logic [CW-1:0]   col;
        logic            eof;
    } exp_t;

    exp_t q[$];
    int total  = 0;
    int bad    = 0;
    int pulses = 0;

    // Hand-computed windows of a 4x4 frame with base 0, in emission order (k=10,11,14,15).
    int win_tab [4][9] = '{
        '{0, 1, 2, 4, 5, 6, 8, 9, 10},
        '{1, 2, 3, 5, 6, 7, 9, 10, 11},
        '{4, 5, 6, 8, 9, 10, 12, 13, 14},
        '{5, 6, 7, 9, 10, 11, 13, 14, 15}
    };
    int win_k   [4] = '{10, 11, 14, 15};
    int win_row [4] = '{2, 2, 3, 3};
    int win_col [4] = '{2, 3, 2, 3};

    task automatic push_exp(input int idx, input int base);
        exp_t e;
        for (int i = 0; i < 9; i++) e.dat[PW*i +: PW] = PW'(win_tab[idx][i] + base);
        e.row = CW'(win_row[idx]);
        e.col = CW'(win_col[idx]);
        e.eof = (idx == 3);
        q.push_back(e);
    endtask

    task automatic send(input int v);
        @(negedge clk);
        idat = PW'(v);
        ival = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        ival = 1'b0;
    endtask

    task automatic send_frame(input int base, input int last_k, input bit gaps);
        for (int k = 0; k <= last_k; k++) begin
            for (int j = 0; j < 4; j++) if (win_k[j] == k) push_exp(j, base);
            send(base + k);
            if (gaps) idle();
        end
    endtask

    task automatic check(input string name, input logic [9*PW-1:0] act, input logic [9*PW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_pulses(input string name, input int req);
        #1;
        check(name, (9*PW)'(pulses), (9*PW)'(req));
        pulses = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oval"}, (9*PW)'(oval), '0);
        check({tag, "_oeof"}, (9*PW)'(oeof), '0);
        check({tag, "_odat"}, odat, '0);
        check({tag, "_orow"}, (9*PW)'(orow), '0);
        check({tag, "_ocol"}, (9*PW)'(ocol), '0);
    endtask

    // Monitor: pops one expectation per presented window.
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (oeof && !oval) begin
                bad++;
                $display("FAIL oeof_without_oval actual=1 required=0");
            end
            if (oval) begin
                pulses++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_window row=%0d col=%0d odat=%0h required=none", orow, ocol, odat);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (odat !== e.dat || orow !== e.row || ocol !== e.col || oeof !== e.eof) begin
                        bad++;
                        $display("FAIL window actual=%0h r%0d c%0d eof%0b required=%0h r%0d c%0d eof%0b",
                                 odat, orow, ocol, oeof, e.dat, e.row, e.col, e.eof);
                    end else begin
                        $display("window row=%0d col=%0d eof=%0b ok", orow, ocol, oeof);
                    end
                end
            end
        end
    end

    initial begin
        // Reset held two cycles, then released.
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset_hold");
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("reset_release");

        // Continuous frame; includes row-1 wrap at k=7 (no window) and k=11 window.
        send_frame(0, 15, 1'b0);
        idle();
        check_pulses("frame_cont_pulses", 4);

        // Same frame with one idle cycle after every pixel.
        send_frame(0, 15, 1'b1);
        idle();
        check_pulses("frame_gaps_pulses", 4);

        // Two back-to-back frames.
        send_frame(0, 15, 1'b0);
        send_frame(100, 15, 1'b0);
        idle();
        check_pulses("two_frames_pulses", 8);

        // Reset mid-frame after k=12, then a fresh frame.
        send_frame(300, 12, 1'b0);
        idle();
        check_pulses("partial_frame_pulses", 2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send_frame(400, 15, 1'b0);
        idle();
        check_pulses("after_reset_pulses", 4);

        check("queue_drained", (9*PW)'(q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
